// File: rtl/ram_port_arbiter_pkg.sv
// mem_arb_pkg: shared constants and types for the two-port RAM arbiter.
//   PORT_A / PORT_B    : requester indices into the req/gnt vectors and tag.port
//   rd_tag_t           : read-return tag {valid, port} carried alongside RAM latency
//   DEF_RD_LAT         : default RAM read latency
//   DEF_DOORBELL_ADDR  : default doorbell word address
package mem_arb_pkg;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int         DEF_RD_LAT        = 1;
  localparam logic [5:0] DEF_DOORBELL_ADDR = 6'h3F;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester-side bus of the RAM arbiter, carrying both
// port A (host) and port B (accelerator) handshakes.
//   x_req/x_we/x_addr/x_wdata : request, held stable until x_gnt
//   x_gnt                     : request accepted this cycle (combinational)
//   x_rvalid/x_rdata          : one-cycle read-return pulse with data
// Modports: master = requesters, slave = arbiter.
interface ram_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);

  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DATA_WIDTH-1:0] a_rdata;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DATA_WIDTH-1:0] b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata
  );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a last-grant pointer.
//   PCLK, PRESETN : clock, async active-low reset
//   req[1:0]      : requests, indexed by PORT_A / PORT_B
//   gnt[1:0]      : one-hot (or zero) combinational grant
// Under contention the port not granted last wins; the pointer only moves on a grant.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1 when B held the most recent grant, so A wins the next tie
  logic last_b;

  always_comb begin
    gnt = 2'b00;
    if (req[PORT_A] && (!req[PORT_B] || last_b)) begin
      gnt[PORT_A] = 1'b1;
    end else if (req[PORT_B]) begin
      gnt[PORT_B] = 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      last_b <= 1'b1;
    end else if (|gnt) begin
      last_b <= gnt[PORT_B];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port word RAM between port A (host) and
// port B (accelerator), one access per cycle, round-robin fair.
//   PCLK, PRESETN            : clock, async active-low reset
//   bus (slave modport)      : A/B request, grant and read-return signals
//   rd_enable, wr_enable     : registered RAM strobes, mutually exclusive
//   raddr, waddr             : registered RAM word address (identical)
//   mem_data_in              : registered RAM write data
//   mem_data_out             : RAM read data, valid RD_LAT cycles after rd_enable
//   irq                      : sticky doorbell, set by B write / cleared by A write
//                              to DOORBELL_ADDR
module ram_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    ADDR_WIDTH    = 6,
  parameter int                    RD_LAT        = DEF_RD_LAT,
  parameter logic [ADDR_WIDTH-1:0] DOORBELL_ADDR = ADDR_WIDTH'(DEF_DOORBELL_ADDR)
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  ram_port_arbiter_if.slave     bus,
  output logic                  rd_enable,
  output logic                  wr_enable,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  irq
);

  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  granted;
  logic                  sel_b;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  rd_port_q;
  rd_tag_t [RD_LAT-1:0]  tag_q;

  assign req[PORT_A] = bus.a_req;
  assign req[PORT_B] = bus.b_req;

  rr_arb2 u_rr_arb2 (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .req     (req),
    .gnt     (gnt)
  );

  assign bus.a_gnt = gnt[PORT_A];
  assign bus.b_gnt = gnt[PORT_B];

  assign granted   = |gnt;
  assign sel_b     = gnt[PORT_B];
  assign sel_we    = sel_b ? bus.b_we    : bus.a_we;
  assign sel_addr  = sel_b ? bus.b_addr  : bus.a_addr;
  assign sel_wdata = sel_b ? bus.b_wdata : bus.a_wdata;

  // Issue stage: address/data hold their last granted value between accesses.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rd_enable   <= 1'b0;
      wr_enable   <= 1'b0;
      addr_q      <= '0;
      mem_data_in <= '0;
      rd_port_q   <= PORT_A;
    end else begin
      rd_enable <= granted & ~sel_we;
      wr_enable <= granted &  sel_we;
      if (granted) begin
        addr_q      <= sel_addr;
        mem_data_in <= sel_wdata;
        rd_port_q   <= sel_b;
      end
    end
  end

  assign raddr = addr_q;
  assign waddr = addr_q;

  // Tag shift register tracks the RAM latency so each return lands on its issuer.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= '{valid: rd_enable, port: rd_port_q};
      for (int i = 1; i < RD_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign bus.a_rvalid = tag_q[RD_LAT-1].valid && (tag_q[RD_LAT-1].port == PORT_A);
  assign bus.b_rvalid = tag_q[RD_LAT-1].valid && (tag_q[RD_LAT-1].port == PORT_B);
  assign bus.a_rdata  = mem_data_out;
  assign bus.b_rdata  = mem_data_out;

  // Doorbell rises together with wr_enable: a B write sets it, an A write clears it.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      irq <= 1'b0;
    end else if (granted && sel_we && (sel_addr == DOORBELL_ADDR)) begin
      irq <= sel_b;
    end
  end

endmodule
